acu_out_port: RTL and testbench

- Output-port controller on the consumer side of the accumulator.
- On an OUT/store strobe from the control unit it captures the current accumulator value into a small FIFO.
- It drains the FIFO to an external consumer over a valid/ready handshake.
- It raises stall so the control unit holds the store while the buffer is full, and flags any dropped writes.

---
 rtl/acu_out_port_if.sv | 27 ++
 rtl/acu_out_port.sv | 74 +++++++
 tb/tb_acu_out_port.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/acu_out_port_if.sv
// rtl/acu_out_port_if.sv - store-side and consumer-side signal bundle for acu_out_port
interface acu_out_port_if #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH + 1);

    logic            st_en;
    logic [SIZE-1:0] acc_val;
    logic            stall;
    logic [SIZE-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic [LW-1:0]   level;
    logic            ovf;
    logic            ovf_clr;

    modport master (
        output st_en, acc_val, out_ready, ovf_clr,
        input  stall, out_data, out_valid, level, ovf
    );

    modport slave (
        input  st_en, acc_val, out_ready, ovf_clr,
        output stall, out_data, out_valid, level, ovf
    );
endinterface

// File: rtl/acu_out_port.sv
// rtl/acu_out_port.sv - accumulator output port: store FIFO drained over valid/ready
module acu_out_port #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rstn,
    acu_out_port_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [SIZE-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [LW-1:0]   level;
    logic            ovf;

    logic full;
    logic valid;
    logic pop;
    logic push;
    logic drop;

    assign full  = (level == LW'(DEPTH));
    assign valid = (level != '0);
    assign pop   = valid && bus.out_ready;
    // A pop in the same edge frees a slot, so a store at full is still accepted.
    assign push  = bus.st_en && (!full || pop);
    assign drop  = bus.st_en && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.acc_val;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Set has priority over clear so a drop is never lost.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (bus.ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    assign bus.out_valid = valid;
    assign bus.out_data  = valid ? mem[rd_ptr] : '0;
    assign bus.stall     = full;
    assign bus.level     = level;
    assign bus.ovf       = ovf;
endmodule

// File: tb/tb_acu_out_port.sv
// tb/tb_acu_out_port.sv - scoreboard bench for acu_out_port
module tb_acu_out_port;
    logic clk;
    logic rstn;
    int   applied;
    int   errors;
    logic [7:0] sb [$];

    acu_out_port_if #(.SIZE(8), .DEPTH(4)) bus ();

    acu_out_port #(.SIZE(8), .DEPTH(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pops happen on the next rising edge; compare on the falling edge before it.
    always @(negedge clk) begin
        if (rstn && bus.out_valid && bus.out_ready) begin
            applied++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none", bus.out_data);
            end else begin
                logic [7:0] exp;
                exp = sb.pop_front();
                if (bus.out_data !== exp) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h", bus.out_data, exp);
                end
            end
        end
    end

    task automatic store(input logic [7:0] v, input bit accept, input bit rdy);
        bus.st_en     = 1'b1;
        bus.acc_val   = v;
        bus.out_ready = rdy;
        if (accept) sb.push_back(v);
        tick();
        bus.st_en = 1'b0;
    endtask

    task automatic drain(input string name);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.level == 0) break;
        end
        bus.out_ready = 1'b0;
        check({name, "_level"}, bus.level, 0);
        check({name, "_sb_left"}, sb.size(), 0);
    endtask

    initial begin
        int sent;
        int cyc;
        bit rdy;
        applied       = 0;
        errors        = 0;
        rstn          = 1'b0;
        bus.st_en     = 1'b0;
        bus.acc_val   = '0;
        bus.out_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        tick();
        check("rst_valid", bus.out_valid, 0);
        check("rst_stall", bus.stall, 0);
        check("rst_level", bus.level, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_data", bus.out_data, 0);

        store(8'hA5, 1, 0);
        check("single_valid", bus.out_valid, 1);
        check("single_data", bus.out_data, 8'hA5);
        check("single_level", bus.level, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_data", bus.out_data, 8'hA5);
            check("hold_valid", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("single_pop_level", bus.level, 0);
        check("single_pop_valid", bus.out_valid, 0);

        bus.out_ready = 1'b1;
        tick();
        check("empty_ready_level", bus.level, 0);
        store(8'h3C, 1, 1);
        check("empty_push_only", bus.level, 1);
        tick();
        bus.out_ready = 1'b0;
        check("empty_push_popped", bus.level, 0);

        store(8'h11, 1, 0);
        store(8'h22, 1, 0);
        store(8'h33, 1, 0);
        store(8'h44, 1, 0);
        check("fill_level", bus.level, 4);
        check("fill_stall", bus.stall, 1);
        store(8'h55, 0, 0);
        check("drop_ovf", bus.ovf, 1);
        check("drop_level", bus.level, 4);
        check("drop_head", bus.out_data, 8'h11);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("ovf_cleared", bus.ovf, 0);
        drain("fill_drain");

        store(8'h11, 1, 0);
        store(8'h22, 1, 0);
        store(8'h33, 1, 0);
        store(8'h44, 1, 0);
        store(8'h55, 1, 1);
        bus.out_ready = 1'b0;
        check("full_pp_level", bus.level, 4);
        check("full_pp_ovf", bus.ovf, 0);
        check("full_pp_head", bus.out_data, 8'h22);
        drain("full_pp_drain");

        sent = 0;
        cyc  = 0;
        rdy  = 1'b1;
        while (sent < 10 && cyc < 100) begin
            bus.out_ready = rdy;
            if (!bus.stall) begin
                bus.st_en   = 1'b1;
                bus.acc_val = 8'(sent + 1);
                sb.push_back(8'(sent + 1));
                sent++;
            end else begin
                bus.st_en = 1'b0;
            end
            tick();
            rdy = !rdy;
            cyc++;
        end
        bus.st_en = 1'b0;
        check("wrap_sent", sent, 10);
        drain("wrap_drain");
        check("wrap_ovf", bus.ovf, 0);

        store(8'hA1, 1, 0);
        store(8'hA2, 1, 0);
        store(8'hA3, 1, 0);
        store(8'hA4, 1, 0);
        bus.ovf_clr = 1'b1;
        store(8'h66, 0, 0);
        bus.ovf_clr = 1'b0;
        check("set_wins_ovf", bus.ovf, 1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("clr_alone_ovf", bus.ovf, 0);
        drain("ovf_drain");

        store(8'hB1, 1, 0);
        store(8'hB2, 1, 0);
        store(8'hB3, 1, 0);
        check("pre_rst_level", bus.level, 3);
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_level", bus.level, 0);
        check("mid_rst_stall", bus.stall, 0);
        check("mid_rst_ovf", bus.ovf, 0);
        check("mid_rst_data", bus.out_data, 0);
        sb.delete();
        tick();
        rstn = 1'b1;
        tick();
        check("post_rst_valid", bus.out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end
endmodule
